// File: rtl/rx_ltssm_substate_checker.sv
// Self-timed RX LTSSM substate checker: per request, runs a ms-based window over
// per-lane ordered-set comparator hits and reports finish plus the next substate.
module rx_ltssm_substate_checker #(
    parameter int MAXLANES   = 16,
    parameter int CLK_PER_MS = 250,
    parameter int TMR_W      = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [4:0]          substate,
    input  logic [MAXLANES-1:0] lane_mask,
    input  logic [MAXLANES-1:0] lane_hit,
    input  logic                rx_elec_idle,
    input  logic                rcvr_cfg_to_idle,
    input  logic [2:0]          train_to_gen,
    output logic                busy,
    output logic                finish,
    output logic [4:0]          exit_to,
    output logic                timed_out,
    output logic                bad_substate,
    output logic [4:0]          required_count,
    output logic [MAXLANES-1:0] reset_os_checkers,
    output logic                descrambler_disable
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ARM       = 3'd1;
    localparam logic [2:0] COUNT     = 3'd2;
    localparam logic [2:0] DONE_OK   = 3'd3;
    localparam logic [2:0] DONE_FAIL = 3'd4;

    localparam logic [4:0] DETECT_QUIET   = 5'd0;
    localparam logic [4:0] DETECT_ACTIVE  = 5'd1;
    localparam logic [4:0] L0_CODE        = 5'd10;
    localparam logic [4:0] RCVR_LOCK      = 5'd11;
    localparam logic [4:0] RCVR_CFG       = 5'd12;
    localparam logic [4:0] RECOVERY_SPEED = 5'd13;
    localparam logic [4:0] PHASE3         = 5'd17;
    localparam logic [4:0] RECOVERY_IDLE  = 5'd18;

    logic [2:0]          stateReg;
    logic [4:0]          latSub;
    logic [MAXLANES-1:0] latMask;
    logic [2:0]          latGen;
    logic [TMR_W-1:0]    timerReg;

    logic                startReq;
    logic                allHit;
    logic                timeout;
    logic                success;
    logic [4:0]          nextSub;

    function automatic logic isBad(input logic [4:0] code);
        return (code == L0_CODE) || (code > RECOVERY_IDLE);
    endfunction

    function automatic logic [4:0] countFor(input logic [4:0] code);
        case (code)
            5'd0, 5'd1, 5'd10:              return 5'd0;
            5'd2, 5'd3, 5'd8, 5'd11, 5'd12,
            5'd18:                          return 5'd8;
            5'd13:                          return 5'd1;
            5'd4, 5'd5, 5'd6, 5'd7, 5'd9,
            5'd14, 5'd15, 5'd16, 5'd17:     return 5'd2;
            default:                        return 5'd0;
        endcase
    endfunction

    function automatic logic [5:0] msFor(input logic [4:0] code);
        case (code)
            5'd0:                           return 6'd12;
            5'd3, 5'd11, 5'd12:             return 6'd48;
            5'd6, 5'd9, 5'd18:              return 6'd2;
            5'd13:                          return 6'd1;
            5'd2, 5'd4, 5'd5, 5'd7, 5'd8,
            5'd14, 5'd15, 5'd16, 5'd17:     return 6'd24;
            default:                        return 6'd0;
        endcase
    endfunction

    function automatic logic [TMR_W-1:0] reloadFor(input logic [4:0] code);
        return TMR_W'(int'(msFor(code)) * CLK_PER_MS);
    endfunction

    // A new request restarts the window unless it repeats the substate in flight.
    assign startReq = req && ((stateReg == IDLE) ||
                      (((stateReg == ARM) || (stateReg == COUNT)) && (substate != latSub)));

    assign allHit  = ((lane_hit & latMask) == latMask) && (latMask != '0);
    // A reload of 0 or 1 both expire in the first COUNT cycle.
    assign timeout = (timerReg <= TMR_W'(1));

    always_comb begin
        success = 1'b0;
        case (latSub)
            DETECT_QUIET:   success = !rx_elec_idle || timeout;
            DETECT_ACTIVE:  success = timeout;
            RECOVERY_SPEED: success = allHit && timeout;
            default:        success = allHit;
        endcase
    end

    always_comb begin
        nextSub = latSub + 5'd1;
        if ((latSub == RCVR_CFG) && rcvr_cfg_to_idle)
            nextSub = RECOVERY_IDLE;
        else if (latSub == PHASE3)
            nextSub = RCVR_LOCK;
        else if (latSub == RECOVERY_IDLE)
            nextSub = L0_CODE;
        else if ((latSub == RECOVERY_SPEED) && (latGen != 3'd3))
            nextSub = RCVR_LOCK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg            <= IDLE;
            latSub              <= '0;
            latMask             <= '0;
            latGen              <= '0;
            timerReg            <= '0;
            busy                <= 1'b0;
            finish              <= 1'b0;
            exit_to             <= '0;
            timed_out           <= 1'b0;
            bad_substate        <= 1'b0;
            required_count      <= '0;
            reset_os_checkers   <= '0;
            descrambler_disable <= 1'b1;
        end else begin
            finish       <= 1'b0;
            timed_out    <= 1'b0;
            bad_substate <= 1'b0;
            if (startReq) begin
                latSub              <= substate;
                latMask             <= lane_mask;
                latGen              <= train_to_gen;
                required_count      <= countFor(substate);
                descrambler_disable <= (substate < L0_CODE);
                reset_os_checkers   <= '0;
                busy                <= 1'b1;
                stateReg            <= ARM;
            end else begin
                case (stateReg)
                    ARM: begin
                        if (isBad(latSub)) begin
                            finish       <= 1'b1;
                            bad_substate <= 1'b1;
                            exit_to      <= DETECT_QUIET;
                            busy         <= 1'b0;
                            stateReg     <= DONE_FAIL;
                        end else begin
                            timerReg          <= reloadFor(latSub);
                            reset_os_checkers <= latMask;
                            stateReg          <= COUNT;
                        end
                    end
                    COUNT: begin
                        if (success) begin
                            finish            <= 1'b1;
                            exit_to           <= nextSub;
                            busy              <= 1'b0;
                            reset_os_checkers <= '0;
                            stateReg          <= DONE_OK;
                        end else if (timeout) begin
                            finish            <= 1'b1;
                            timed_out         <= 1'b1;
                            exit_to           <= DETECT_QUIET;
                            busy              <= 1'b0;
                            reset_os_checkers <= '0;
                            stateReg          <= DONE_FAIL;
                        end else begin
                            timerReg <= timerReg - TMR_W'(1);
                        end
                    end
                    DONE_OK, DONE_FAIL: stateReg <= IDLE;
                    default:            stateReg <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_ltssm_substate_checker.sv
// Randomized bench for rx_ltssm_substate_checker: each window's finish time and
// result are predicted from the substate table and the driven hit/idle timing.
module tb_rx_ltssm_substate_checker;

    localparam int CPM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [4:0]  substate = '0;
    logic [15:0] lane_mask = '0;
    logic [15:0] lane_hit = '0;
    logic        rx_elec_idle = 1'b1;
    logic        rcvr_cfg_to_idle = 1'b0;
    logic [2:0]  train_to_gen = '0;
    logic        busy, finish, timed_out, bad_substate, descrambler_disable;
    logic [4:0]  exit_to, required_count;
    logic [15:0] reset_os_checkers;

    int nCompared = 0;
    int nMismatch = 0;

    int reqTab[19] = '{0, 0, 8, 8, 2, 2, 2, 2, 8, 2, 0, 8, 8, 1, 2, 2, 2, 2, 8};
    int msTab[19]  = '{12, 0, 24, 48, 24, 24, 2, 24, 24, 2, 0, 48, 48, 1, 24, 24, 24, 24, 2};

    rx_ltssm_substate_checker #(.MAXLANES(16), .CLK_PER_MS(CPM), .TMR_W(24)) dut (
        .clk(clk), .reset(reset), .req(req), .substate(substate),
        .lane_mask(lane_mask), .lane_hit(lane_hit), .rx_elec_idle(rx_elec_idle),
        .rcvr_cfg_to_idle(rcvr_cfg_to_idle), .train_to_gen(train_to_gen),
        .busy(busy), .finish(finish), .exit_to(exit_to), .timed_out(timed_out),
        .bad_substate(bad_substate), .required_count(required_count),
        .reset_os_checkers(reset_os_checkers), .descrambler_disable(descrambler_disable)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int expExit(input int sub, input int gen, input bit cfgIdle);
        if (sub == 12 && cfgIdle) return 18;
        if (sub == 17) return 11;
        if (sub == 18) return 10;
        if (sub == 13 && gen != 3) return 11;
        return sub + 1;
    endfunction

    // hitAt / quietAt: 1-based COUNT cycle from which all masked lanes hit /
    // electrical idle drops; 0 means never.
    task automatic runWindow(input int sub, input logic [15:0] mask, input int gen,
                             input bit cfgIdle, input int hitAt, input int quietAt);
        bit bad, ok;
        int rc, tLen, k, expEdge, j;
        logic [15:0] lowBit;
        bad = (sub == 10) || (sub > 18);
        rc = bad ? 0 : reqTab[sub];
        tLen = bad ? 0 : ((msTab[sub] * CPM < 1) ? 1 : msTab[sub] * CPM);
        ok = 1'b0;
        k = tLen;
        if (!bad) begin
            if (sub == 0) begin
                ok = 1'b1;
                if (quietAt >= 1 && quietAt <= tLen) k = quietAt;
            end else if (sub == 1) begin
                ok = 1'b1;
            end else if (sub == 13) begin
                ok = (mask != 0) && hitAt >= 1 && hitAt <= tLen;
            end else begin
                ok = (mask != 0) && hitAt >= 1 && hitAt <= tLen;
                if (ok) k = hitAt;
            end
        end
        expEdge = bad ? 1 : k + 1;
        lowBit = mask & (~mask + 16'd1);

        req = 1'b1; substate = 5'(sub); lane_mask = mask; train_to_gen = 3'(gen);
        rcvr_cfg_to_idle = cfgIdle; lane_hit = '0; rx_elec_idle = 1'b1;
        @(posedge clk); #1;
        req = 1'b0;
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_reqcount", 32'(required_count), 32'(rc));
        chk("arm_checkers", 32'(reset_os_checkers), 32'd0);
        chk("arm_finish", 32'(finish), 32'd0);
        for (int e = 1; e <= expEdge; e++) begin
            j = e - 1;
            if (hitAt >= 1 && j >= hitAt) lane_hit = mask | 16'($urandom);
            else                          lane_hit = 16'($urandom) & ~lowBit;
            rx_elec_idle = !(quietAt >= 1 && j >= quietAt);
            @(posedge clk); #1;
            if (e == expEdge) begin
                chk("fin_finish", 32'(finish), 32'd1);
                chk("fin_exit", 32'(exit_to), ok ? 32'(expExit(sub, gen, cfgIdle)) : 32'd0);
                chk("fin_timedout", 32'(timed_out), 32'(!ok && !bad));
                chk("fin_bad", 32'(bad_substate), 32'(bad));
                chk("fin_busy", 32'(busy), 32'd0);
                chk("fin_checkers", 32'(reset_os_checkers), 32'd0);
                chk("fin_descr", 32'(descrambler_disable), 32'(sub < 10));
            end else begin
                chk("win_finish", 32'(finish), 32'd0);
                chk("win_checkers", 32'(reset_os_checkers), 32'(mask));
            end
        end
        lane_hit = '0; rx_elec_idle = 1'b1;
        @(posedge clk); #1;
        chk("idle_finish", 32'(finish), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        $display("window sub=%0d mask=%04h gen=%0d hitAt=%0d quietAt=%0d -> edge=%0d ok=%0b exit=%0d",
                 sub, mask, gen, hitAt, quietAt, expEdge, ok, exit_to);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", nCompared);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_finish", 32'(finish), 32'd0);
        chk("rst_exit", 32'(exit_to), 32'd0);
        chk("rst_reqcount", 32'(required_count), 32'd0);
        chk("rst_checkers", 32'(reset_os_checkers), 32'd0);
        chk("rst_descr", 32'(descrambler_disable), 32'd1);
        reset = 1'b0;
        @(posedge clk); #1;

        runWindow(1, 16'h00FF, 0, 1'b0, 0, 0);
        runWindow(2, 16'h000F, 0, 1'b0, 5, 0);
        runWindow(11, 16'h0005, 0, 1'b0, 0, 0);
        runWindow(13, 16'h0003, 2, 1'b0, 1, 0);
        runWindow(13, 16'h0003, 3, 1'b0, 1, 0);
        runWindow(12, 16'h0F00, 0, 1'b1, 3, 0);
        runWindow(18, 16'h0001, 0, 1'b0, 2, 0);
        runWindow(25, 16'h0001, 0, 1'b0, 1, 0);
        runWindow(0, 16'h0000, 0, 1'b0, 0, 7);
        runWindow(2, 16'h0000, 0, 1'b0, 1, 0);

        // Abort: same-substate repeat is ignored, a different one restarts.
        req = 1'b1; substate = 5'd3; lane_mask = 16'h00F0; lane_hit = '0;
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            req = (i == 5);
            @(posedge clk); #1;
            req = 1'b0;
            chk("abort_finish", 32'(finish), 32'd0);
            chk("abort_checkers", 32'(reset_os_checkers), 32'h00F0);
        end
        req = 1'b1; substate = 5'd4; lane_mask = 16'h0003;
        @(posedge clk); #1;
        req = 1'b0; lane_hit = 16'h0003;
        chk("rearm_checkers", 32'(reset_os_checkers), 32'd0);
        chk("rearm_busy", 32'(busy), 32'd1);
        chk("rearm_reqcount", 32'(required_count), 32'd2);
        @(posedge clk); #1;
        chk("rearm_count_checkers", 32'(reset_os_checkers), 32'h0003);
        chk("rearm_count_finish", 32'(finish), 32'd0);
        @(posedge clk); #1;
        chk("rearm_finish", 32'(finish), 32'd1);
        chk("rearm_exit", 32'(exit_to), 32'd5);
        chk("rearm_timedout", 32'(timed_out), 32'd0);
        lane_hit = '0;
        @(posedge clk); #1;
        $display("abort test done exit=%0d", exit_to);

        // Asynchronous reset in the middle of a window.
        req = 1'b1; substate = 5'd11; lane_mask = 16'h0001;
        @(posedge clk); #1;
        req = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_checkers", 32'(reset_os_checkers), 32'd0);
        chk("mid_rst_reqcount", 32'(required_count), 32'd0);
        chk("mid_rst_descr", 32'(descrambler_disable), 32'd1);
        chk("mid_rst_exit", 32'(exit_to), 32'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("post_rst_finish", 32'(finish), 32'd0);
        end
        $display("reset test done busy=%0b", busy);

        for (int t = 0; t < 30; t++) begin
            int sub, hitAt, quietAt, span;
            logic [15:0] mask;
            sub = $urandom_range(0, 22);
            mask = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            span = (sub <= 18) ? msTab[sub] * CPM + 3 : 4;
            hitAt = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, span);
            quietAt = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, span);
            runWindow(sub, mask, $urandom_range(0, 7), 1'($urandom), hitAt, quietAt);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
